// File: rtl/in_port_buffer.sv
// in_port_buffer: input-port FIFO feeding IN instructions; optional same-cycle bypass via INPORT_BYPASS_EN
module in_port_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [0:0]        state_q, state_d;
    logic              empty, push, pop, byp, wr_en;

    assign empty    = count_q == '0;
    assign in_ready = count_q != CW'(DEPTH);
    assign push     = in_valid && in_ready;
    assign pop      = rd_en && !empty;
`ifdef INPORT_BYPASS_EN
    assign byp      = rd_en && empty && push;
`else
    assign byp      = 1'b0;
`endif
    assign wr_en    = push && !byp;
    assign stall    = rd_en && empty && !byp;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;

    // Next-state for pointers, occupancy and the registered read port
    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        rd_data_d  = pop ? mem_q[rd_ptr_q] : byp ? in_data : rd_data_q;
        rd_valid_d = pop || byp;
    end

    // Read FSM: WAIT while an IN is held off by an empty buffer
    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE)
            state_d = (rd_en && empty && !byp) ? ST_WAIT : ST_IDLE;
        else
            state_d = (!rd_en || pop || byp) ? ST_IDLE : ST_WAIT;
    end

    // Storage write: only the slot at wr_ptr changes
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q] = in_data;
    end

    // Storage has no reset; contents are meaningless while count is 0
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state, cleared asynchronously so outputs drop without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            state_q    <= state_d;
        end
    end
endmodule

// File: tb/tb_in_port_buffer.sv
// tb_in_port_buffer: scoreboard bench for in_port_buffer (follows INPORT_BYPASS_EN)
module tb_in_port_buffer;
    localparam int DEPTH = 4;
`ifdef INPORT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    logic [15:0] sb [$];
    logic [15:0] last_d = '0;

    in_port_buffer #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .stall(stall), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then registered outputs after the edge
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        logic       acc, exp_v, bypass;
        logic [15:0] exp_d;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        rd_en    = r;
        #1;
        acc    = v && (sb.size() < DEPTH);
        bypass = BYP && acc && r && (sb.size() == 0);
        chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
        chk("stall", 32'(stall), 32'(r && sb.size() == 0 && !bypass));
        exp_v = 1'b0;
        exp_d = last_d;
        if (r && sb.size() != 0) begin
            exp_v = 1'b1;
            exp_d = sb.pop_front();
        end else if (bypass) begin
            exp_v = 1'b1;
            exp_d = d;
        end
        if (acc && !bypass) sb.push_back(d);
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("rd_data", 32'(rd_data), 32'(exp_d));
        chk("count", 32'(count), 32'(sb.size()));
        last_d = exp_d;
    endtask

    initial begin
        #12;
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Reset mid-burst with count=3 and a fresh pop on rd_data
        step(1, 16'hA001, 0);
        step(1, 16'hA002, 0);
        step(1, 16'hA003, 0);
        step(1, 16'hA004, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        last_d = '0;
        in_valid = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Fill, 5th word held off
        step(1, 16'h1111, 0);
        step(1, 16'h2222, 0);
        step(1, 16'h3333, 0);
        step(1, 16'h4444, 0);
        step(1, 16'h5555, 0);
        // Held off even while a pop occurs in the same cycle
        step(1, 16'h5555, 1);
        step(0, 16'h0000, 0);
        // Drain the rest, then a further rd_en stalls
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        // Wrap: interleaved push/pop across the pointer wrap
        step(1, 16'h0000, 0);
        for (int i = 1; i < 10; i++) step(1, 16'(i), 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        // Stall for three cycles, then the word arrives
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(1, 16'hBEEF, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        // Same-cycle push and IN on an empty buffer
        step(1, 16'hCAFE, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        // Flush: rd_en drops while stalled, then a later push stays buffered
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        step(1, 16'h7777, 0);
        step(0, 16'h0000, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
